// File: rtl/micron_burst_ctrl.sv
// Synchronous-burst controller bridging a request/done bus to Micron CellularRAM pins.
// Latency: first data beat 1+LATENCY cycles after breq is taken; mwait stalls beats indefinitely.
module micron_burst_ctrl #(
  parameter int   A_WIDTH   = 16,
  parameter int   D_WIDTH   = 16,
  parameter int   LATENCY   = 4,
  parameter int   MAX_BURST = 16,
  parameter logic WAIT_POL  = 1'b1,
  parameter int   BL_W      = $clog2(MAX_BURST + 1)
) (
  input  logic               clk50MHz,
  input  logic               rst,
  input  logic               breq,
  input  logic               bwe,
  input  logic [A_WIDTH-1:0] baddr,
  input  logic [BL_W-1:0]    bburst,
  input  logic [1:0]         bbe_L,
  input  logic [D_WIDTH-1:0] bwdata,
  output logic               bwdata_rd,
  output logic [D_WIDTH-1:0] brdata,
  output logic               brvalid,
  output logic               bbusy,
  output logic               bdone,
  output logic [A_WIDTH-1:0] maddr,
  inout  wire  [D_WIDTH-1:0] mdata,
  output logic               moe_L,
  output logic               mwe_L,
  output logic               madv_L,
  output logic               mce_L,
  output logic               mub_L,
  output logic               mlb_L,
  output logic               mclk,
  output logic               mcre,
  input  logic               mwait
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ADDR = 3'd1;
  localparam logic [2:0] LAT  = 3'd2;
  localparam logic [2:0] DATA = 3'd3;
  localparam logic [2:0] ENDS = 3'd4;

  localparam logic [3:0] LAT_LAST = 4'(LATENCY - 1);

  logic [2:0]         state;
  logic               we_q;
  logic [A_WIDTH-1:0] addr_q;
  logic [1:0]         be_l_q;
  logic [BL_W-1:0]    beats_left;
  logic [3:0]         lat_cnt;
  logic [BL_W-1:0]    beats_req;
  logic               in_burst;
  logic               beat_done;

  // A zero-length request still moves one beat; oversize requests are clipped.
  always_comb begin
    if (bburst == '0)
      beats_req = BL_W'(1);
    else if (bburst > BL_W'(MAX_BURST))
      beats_req = BL_W'(MAX_BURST);
    else
      beats_req = bburst;
  end

  assign in_burst  = (state == ADDR) || (state == LAT) || (state == DATA);
  assign beat_done = (state == DATA) && (mwait != WAIT_POL);

  always_ff @(posedge clk50MHz) begin
    if (rst) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_l_q     <= 2'b11;
      beats_left <= '0;
      lat_cnt    <= '0;
      brdata     <= '0;
      brvalid    <= 1'b0;
    end else begin
      brvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (breq) begin
            we_q       <= bwe;
            addr_q     <= baddr;
            be_l_q     <= bbe_L;
            beats_left <= beats_req;
            lat_cnt    <= '0;
            state      <= ADDR;
          end
        end
        ADDR: state <= LAT;
        LAT: begin
          if (lat_cnt == LAT_LAST)
            state <= DATA;
          else
            lat_cnt <= lat_cnt + 4'd1;
        end
        DATA: begin
          if (beat_done) begin
            if (!we_q) begin
              brdata  <= mdata;
              brvalid <= 1'b1;
            end
            beats_left <= beats_left - BL_W'(1);
            if (beats_left == BL_W'(1))
              state <= ENDS;
          end
        end
        ENDS: begin
          // Return the read-data and counters to their idle values.
          brdata     <= '0;
          beats_left <= '0;
          lat_cnt    <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bbusy     = (state != IDLE);
  assign bdone     = (state == ENDS);
  assign bwdata_rd = beat_done && we_q;

  assign maddr  = bbusy ? addr_q : '0;
  assign mce_L  = !in_burst;
  assign madv_L = (state != ADDR);
  assign mwe_L  = !(in_burst && we_q);
  assign moe_L  = !((state == DATA) && !we_q);
  assign mub_L  = in_burst ? be_l_q[1] : 1'b1;
  assign mlb_L  = in_burst ? be_l_q[0] : 1'b1;
  assign mcre   = 1'b0;
  assign mclk   = in_burst & clk50MHz;

  // Write data is presented for the whole DATA phase so a stalled beat stays on the pins.
  assign mdata = ((state == DATA) && we_q) ? bwdata : {D_WIDTH{1'bz}};

endmodule

// File: tb/tb_micron_burst_ctrl.sv
// Scoreboard bench for micron_burst_ctrl with a small burst-RAM responder.
module tb_micron_burst_ctrl;

  localparam int LAT = 4;

  logic        clk50MHz = 1'b0;
  logic        rst = 1'b1;
  logic        breq = 1'b0;
  logic        bwe = 1'b0;
  logic [15:0] baddr = '0;
  logic [4:0]  bburst = '0;
  logic [1:0]  bbe_L = 2'b11;
  logic [15:0] bwdata;
  logic        bwdata_rd;
  logic [15:0] brdata;
  logic        brvalid, bbusy, bdone;
  logic [15:0] maddr;
  wire  [15:0] mdata;
  logic        moe_L, mwe_L, madv_L, mce_L, mub_L, mlb_L, mclk, mcre;
  logic        mwait = 1'b0;

  micron_burst_ctrl dut (
    .clk50MHz(clk50MHz), .rst(rst), .breq(breq), .bwe(bwe), .baddr(baddr),
    .bburst(bburst), .bbe_L(bbe_L), .bwdata(bwdata), .bwdata_rd(bwdata_rd),
    .brdata(brdata), .brvalid(brvalid), .bbusy(bbusy), .bdone(bdone),
    .maddr(maddr), .mdata(mdata), .moe_L(moe_L), .mwe_L(mwe_L), .madv_L(madv_L),
    .mce_L(mce_L), .mub_L(mub_L), .mlb_L(mlb_L), .mclk(mclk), .mcre(mcre),
    .mwait(mwait)
  );

  always #10 clk50MHz = ~clk50MHz;

  int cyc = 0;
  always @(posedge clk50MHz) cyc <= cyc + 1;

  // Burst RAM: word at address a holds 0x00A0 + a.
  logic [7:0]  ptr = '0;
  logic [15:0] ram_dat;
  assign ram_dat = 16'h00A0 + {8'h00, ptr};
  assign mdata = (!moe_L) ? ram_dat : 16'hzzzz;
  always @(posedge clk50MHz) begin
    if (!madv_L) ptr <= maddr[7:0];
    else if (!moe_L && !mwait) ptr <= ptr + 8'd1;
  end

  // Write source: presents the next word after each accepted beat.
  logic [15:0] wr_idx = '0;
  assign bwdata = 16'h5000 + wr_idx;
  always @(posedge clk50MHz) if (bwdata_rd) wr_idx <= wr_idx + 16'd1;

  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] rd_q[$];
  logic [15:0] wr_q[$];
  int done_q[$];
  int wr_next = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_ev(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: unexpected event (cycle %0d)", nm, cyc);
  endtask

  // Monitor
  always @(negedge clk50MHz) begin
    if (brvalid) begin
      if (rd_q.size() == 0) fail_ev("brvalid");
      else chk("read_beat", brdata, rd_q.pop_front());
    end
    if (bwdata_rd) begin
      if (wr_q.size() == 0) fail_ev("bwdata_rd");
      else chk("write_beat", mdata, wr_q.pop_front());
    end
    if (bdone) begin
      if (done_q.size() == 0) fail_ev("bdone");
      else chk("bdone_cycle", cyc, done_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk50MHz);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic wait_idle();
    int k = 0;
    while (bbusy && k < 100) begin
      tick();
      k++;
    end
    if (k >= 100) fail_ev("idle_timeout");
    tick();
  endtask

  task automatic issue(input logic we, input logic [15:0] addr, input logic [4:0] bl,
                       input logic [1:0] be, output int t0);
    breq = 1'b1; bwe = we; baddr = addr; bburst = bl; bbe_L = be;
    tick();
    t0 = cyc;
    breq = 1'b0;
  endtask

  task automatic push_wr(input int n);
    for (int i = 0; i < n; i++) begin
      wr_q.push_back(16'h5000 + 16'(wr_next));
      wr_next++;
    end
  endtask

  function automatic logic released(input logic [15:0] v);
    return (v === 16'hzzzz) || (v === 16'h0000);
  endfunction

  initial begin
    int t0, t1, wb;
    logic [15:0] exp_stall;
    repeat (3) tick();
    chk("reset_ctl_L", {mce_L, moe_L, mwe_L, madv_L, mub_L, mlb_L}, 6'b111111);
    chk("reset_misc", {mcre, mclk, bbusy, bdone, brvalid, bwdata_rd}, 6'b0);
    chk("reset_brdata", brdata, 16'h0);
    chk("reset_maddr", maddr, 16'h0);
    chk("reset_mdata_rel", released(mdata), 1'b1);
    rst = 1'b0;
    tick();

    // Read, 4 beats from address 0
    issue(1'b0, 16'h0000, 5'd4, 2'b00, t0);
    for (int k = 0; k < 4; k++) rd_q.push_back(16'h00A0 + 16'(k));
    done_q.push_back(t0 + 1 + LAT + 4);
    chk("addr_phase", {mce_L, madv_L, mwe_L, bbusy}, 4'b0011);
    tick();
    chk("lat_phase", {mce_L, madv_L, moe_L}, 3'b011);
    wait_cyc(t0 + 1 + LAT);
    chk("read_data_phase", {mce_L, moe_L, mclk}, 3'b001);
    wait_idle();

    // Write, 3 beats, mwait asserted for two cycles on beat 2
    issue(1'b1, 16'h0030, 5'd3, 2'b00, t0);
    wb = wr_next;
    push_wr(3);
    done_q.push_back(t0 + 1 + LAT + 3 + 2);
    chk("write_addr_phase", {mwe_L, madv_L}, 2'b00);
    chk("write_maddr", maddr, 16'h0030);
    wait_cyc(t0 + 2 + LAT);
    mwait = 1'b1;
    exp_stall = 16'h5000 + 16'(wb + 1);
    for (int s = 0; s < 2; s++) begin
      #5;
      chk("stall_mdata", mdata, exp_stall);
      chk("stall_no_rd", bwdata_rd, 1'b0);
      tick();
    end
    mwait = 1'b0;
    wait_idle();
    chk("write_idle_rel", released(mdata), 1'b1);

    // Zero-length read becomes one beat
    issue(1'b0, 16'h0040, 5'd0, 2'b00, t0);
    rd_q.push_back(16'h00E0);
    done_q.push_back(t0 + 1 + LAT + 1);
    wait_idle();

    // Oversize read clipped to 16 beats
    issue(1'b0, 16'h0010, 5'd20, 2'b00, t0);
    for (int k = 0; k < 16; k++) rd_q.push_back(16'h00B0 + 16'(k));
    done_q.push_back(t0 + 1 + LAT + 16);
    wait_idle();

    // Reset during write beat 2
    issue(1'b1, 16'h0050, 5'd4, 2'b00, t0);
    push_wr(2);
    wait_cyc(t0 + 2 + LAT);
    rst = 1'b1;
    tick();
    chk("rst_mid_busy", bbusy, 1'b0);
    chk("rst_mid_ce", mce_L, 1'b1);
    chk("rst_mid_mdata_rel", released(mdata), 1'b1);
    rst = 1'b0;
    tick();
    tick();

    // breq held across a burst; upper byte disabled
    breq = 1'b1; bwe = 1'b0; baddr = 16'h0020; bburst = 5'd2; bbe_L = 2'b10;
    tick();
    t0 = cyc;
    t1 = t0 + 1 + LAT + 2 + 2;
    for (int r = 0; r < 2; r++) begin
      rd_q.push_back(16'h00C0);
      rd_q.push_back(16'h00C1);
    end
    done_q.push_back(t0 + 1 + LAT + 2);
    done_q.push_back(t1 + 1 + LAT + 2);
    for (int c = 0; c < 1 + LAT + 2; c++) begin
      chk("be_ub_lb", {mub_L, mlb_L}, 2'b10);
      tick();
    end
    chk("end_phase", {bbusy, mce_L, moe_L}, 3'b111);
    tick();
    chk("idle_between", bbusy, 1'b0);
    tick();
    chk("second_addr", {madv_L, bbusy}, 2'b01);
    breq = 1'b0;
    wait_idle();

    repeat (4) tick();
    chk("rd_q_empty", rd_q.size(), 0);
    chk("wr_q_empty", wr_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
